// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single integer register-file write port between the EX stage and
// the load/store queue. EX write-backs always win. Load returns are buffered in
// a small FIFO and drained into cycles where EX does not write. An age counter
// on the FIFO head raises exs_hold_o so that a queued load cannot be starved
// forever. lsq_done_o tells the ID-stage scoreboard that a load has reached the
// register file, so it can clear its pending bit.
//
// Parameters
//   DEPTH       LSQ return FIFO entries (power of 2, >= 2)
//   STARVE_MAX  cycles a blocked FIFO head may wait before exs_hold_o rises (>= 1)
//
// Optional feature macro
//   WBARB_BYPASS_EN  when defined, a load return that arrives while the FIFO is
//                    empty and EX is idle goes straight to the register file in
//                    the same cycle instead of being queued.
//
// Ports
//   clk_i, resetb_i        clock, asynchronous active-low reset
//   clk_en_i               clock enable; 0 freezes all state
//   exs_regd_wr_i/addr/data  EX write-back request (cannot be stalled)
//   lsq_reg_wr_i/addr/data   LSQ load return (held until lsq_reg_rdy_o)
//   lsq_reg_rdy_o          LSQ return accepted this cycle (FIFO not full)
//   rf_wr_o/addr/data      register-file write port (combinational)
//   lsq_done_o/addr        a load result was written this cycle
//   exs_hold_o             request to stop issuing EX write-backs
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,
    input  logic        exs_regd_wr_i,
    input  logic [4:0]  exs_regd_addr_i,
    input  logic [31:0] exs_regd_data_i,
    input  logic        lsq_reg_wr_i,
    input  logic [4:0]  lsq_reg_addr_i,
    input  logic [31:0] lsq_reg_data_i,
    output logic        lsq_reg_rdy_o,
    output logic        rf_wr_o,
    output logic [4:0]  rf_addr_o,
    output logic [31:0] rf_data_o,
    output logic        lsq_done_o,
    output logic [4:0]  lsq_done_addr_o,
    output logic        exs_hold_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [4:0]  addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    // Pointers carry one wrap bit above the index so full and empty differ.
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             empty, full;
    logic             push, pop, bypass;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;
    logic             wr_req, done_req, active;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;
    logic [AGE_W-1:0] age, age_nxt;

    assign wr_idx    = wr_ptr[PTR_W-1:0];
    assign rd_idx    = rd_ptr[PTR_W-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
    assign head_addr = addr_mem[rd_idx];
    assign head_data = data_mem[rd_idx];

    assign lsq_reg_rdy_o = ~full;

    // Write-port selection: EX first, then FIFO head, then (optionally) bypass.
    always_comb begin
        wr_req   = 1'b0;
        done_req = 1'b0;
        bypass   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        if (exs_regd_wr_i) begin
            wr_req   = 1'b1;
            sel_addr = exs_regd_addr_i;
            sel_data = exs_regd_data_i;
        end else if (!empty) begin
            wr_req   = 1'b1;
            done_req = 1'b1;
            sel_addr = head_addr;
            sel_data = head_data;
        end
`ifdef WBARB_BYPASS_EN
        else if (lsq_reg_wr_i) begin
            wr_req   = 1'b1;
            done_req = 1'b1;
            bypass   = 1'b1;
            sel_addr = lsq_reg_addr_i;
            sel_data = lsq_reg_data_i;
        end
`endif
    end

    // A frozen or reset cycle must never look like a write to downstream logic.
    assign active          = clk_en_i & resetb_i;
    assign rf_wr_o         = wr_req & (sel_addr != 5'd0) & active;
    assign rf_addr_o       = sel_addr;
    assign rf_data_o       = sel_data;
    assign lsq_done_o      = done_req & active;
    assign lsq_done_addr_o = sel_addr;

    // An x0 load still pops so the scoreboard sees its done pulse.
    assign pop  = done_req & ~bypass & clk_en_i;
    assign push = lsq_reg_wr_i & ~full & ~bypass & clk_en_i;

    // Head age: counts cycles the head loses to EX, saturating.
    always_comb begin
        age_nxt = age;
        if (pop || empty) begin
            age_nxt = '0;
        end else if (exs_regd_wr_i && (age < AGE_MAX)) begin
            age_nxt = age + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN) begin
            if (age_nxt == AGE_MAX) state_nxt = HOLD;
        end else begin
            if (pop) state_nxt = RUN;
        end
    end

    assign exs_hold_o = (state == HOLD);

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            age    <= '0;
            state  <= RUN;
        end else if (clk_en_i) begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            age   <= age_nxt;
            state <= state_nxt;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_idx] <= lsq_reg_addr_i;
            data_mem[wr_idx] <= lsq_reg_data_i;
        end
    end

`ifndef SYNTHESIS
    // The scoreboard must never let EX target a register with a queued load.
    logic [PTR_W:0] count;
    logic           ex_hits_queue;

    assign count = wr_ptr - rd_ptr;

    always_comb begin
        ex_hits_queue = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (({1'b0, PTR_W'(j) - rd_idx} < count) &&
                (addr_mem[PTR_W'(j)] == exs_regd_addr_i)) begin
                ex_hits_queue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (resetb_i && clk_en_i && exs_regd_wr_i && (exs_regd_addr_i != 5'd0)) begin
            assert (!ex_hits_queue);
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed bench for wb_port_arbiter in its default build (DEPTH=4,
// STARVE_MAX=8, bypass disabled). A table of per-cycle vectors covers basic
// arbitration, x0 handling and clock-enable freezing; hand-written sequences
// cover starvation hold, FIFO full back-pressure and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    logic        clk_i = 1'b0;
    logic        resetb_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic        exs_regd_wr_i = 1'b0;
    logic [4:0]  exs_regd_addr_i = '0;
    logic [31:0] exs_regd_data_i = '0;
    logic        lsq_reg_wr_i = 1'b0;
    logic [4:0]  lsq_reg_addr_i = '0;
    logic [31:0] lsq_reg_data_i = '0;
    logic        lsq_reg_rdy_o;
    logic        rf_wr_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        lsq_done_o;
    logic [4:0]  lsq_done_addr_o;
    logic        exs_hold_o;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk_i           (clk_i),
        .resetb_i        (resetb_i),
        .clk_en_i        (clk_en_i),
        .exs_regd_wr_i   (exs_regd_wr_i),
        .exs_regd_addr_i (exs_regd_addr_i),
        .exs_regd_data_i (exs_regd_data_i),
        .lsq_reg_wr_i    (lsq_reg_wr_i),
        .lsq_reg_addr_i  (lsq_reg_addr_i),
        .lsq_reg_data_i  (lsq_reg_data_i),
        .lsq_reg_rdy_o   (lsq_reg_rdy_o),
        .rf_wr_o         (rf_wr_o),
        .rf_addr_o       (rf_addr_o),
        .rf_data_o       (rf_data_o),
        .lsq_done_o      (lsq_done_o),
        .lsq_done_addr_o (lsq_done_addr_o),
        .exs_hold_o      (exs_hold_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        exs_wr;
        logic [4:0]  exs_addr;
        logic [31:0] exs_data;
        logic        lsq_wr;
        logic [4:0]  lsq_addr;
        logic [31:0] lsq_data;
        logic        en;
        logic        rf_wr;
        logic [4:0]  rf_addr;
        logic [31:0] rf_data;
        logic        done;
        logic [4:0]  done_addr;
        logic        rdy;
        logic        hold;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic lw, input logic [4:0] la, input logic [31:0] ld,
        input logic en,
        input logic rw, input logic [4:0] ra, input logic [31:0] rd,
        input logic dn, input logic [4:0] da, input logic rdy, input logic hold);
        vec_t v;
        v.exs_wr = ew; v.exs_addr = ea; v.exs_data = ed;
        v.lsq_wr = lw; v.lsq_addr = la; v.lsq_data = ld;
        v.en = en;
        v.rf_wr = rw; v.rf_addr = ra; v.rf_data = rd;
        v.done = dn; v.done_addr = da; v.rdy = rdy; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic lw, input logic [4:0] la, input logic [31:0] ld,
        input logic en);
        exs_regd_wr_i   = ew;
        exs_regd_addr_i = ea;
        exs_regd_data_i = ed;
        lsq_reg_wr_i    = lw;
        lsq_reg_addr_i  = la;
        lsq_reg_data_i  = ld;
        clk_en_i        = en;
    endtask

    // Address/data are only compared when the matching strobe is expected.
    task automatic check_out(input string tag,
        input logic rw, input logic [4:0] ra, input logic [31:0] rd,
        input logic dn, input logic [4:0] da, input logic rdy, input logic hold);
        chk({tag, " rf_wr"}, {31'd0, rf_wr_o}, {31'd0, rw});
        if (rw) begin
            chk({tag, " rf_addr"}, {27'd0, rf_addr_o}, {27'd0, ra});
            chk({tag, " rf_data"}, rf_data_o, rd);
        end
        chk({tag, " done"}, {31'd0, lsq_done_o}, {31'd0, dn});
        if (dn) chk({tag, " done_addr"}, {27'd0, lsq_done_addr_o}, {27'd0, da});
        chk({tag, " rdy"}, {31'd0, lsq_reg_rdy_o}, {31'd0, rdy});
        chk({tag, " hold"}, {31'd0, exs_hold_o}, {31'd0, hold});
    endtask

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ew ea ed            lw la ld            en  rw ra rd            dn da rdy hold
        vecs[0]  = mk(0, 0, 0,          1, 5, 32'hDEADBEEF, 1, 0, 0, 0,            0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0,          0, 0, 0,            1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 0);
        vecs[2]  = mk(0, 0, 0,          0, 0, 0,            1, 0, 0, 0,            0, 0, 1, 0);
        vecs[3]  = mk(1, 3, 32'h33,     1, 7, 32'h77,       1, 1, 3, 32'h33,       0, 0, 1, 0);
        vecs[4]  = mk(1, 3, 32'h33,     0, 0, 0,            1, 1, 3, 32'h33,       0, 0, 1, 0);
        vecs[5]  = mk(1, 3, 32'h33,     0, 0, 0,            1, 1, 3, 32'h33,       0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0,          0, 0, 0,            1, 1, 7, 32'h77,       1, 7, 1, 0);
        vecs[7]  = mk(0, 0, 0,          0, 0, 0,            1, 0, 0, 0,            0, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0,          1, 0, 32'h11,       1, 0, 0, 0,            0, 0, 1, 0);
        vecs[9]  = mk(0, 0, 0,          0, 0, 0,            1, 0, 0, 0,            1, 0, 1, 0);
        vecs[10] = mk(1, 0, 32'h99,     0, 0, 0,            1, 0, 0, 0,            0, 0, 1, 0);
        vecs[11] = mk(0, 0, 0,          0, 0, 0,            1, 0, 0, 0,            0, 0, 1, 0);
        vecs[12] = mk(0, 0, 0,          1, 9, 32'hAA,       0, 0, 0, 0,            0, 0, 1, 0);
        vecs[13] = mk(0, 0, 0,          0, 0, 0,            1, 0, 0, 0,            0, 0, 1, 0);
        vecs[14] = mk(0, 0, 0,          1, 9, 32'hAA,       1, 0, 0, 0,            0, 0, 1, 0);
        vecs[15] = mk(0, 0, 0,          0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0);
        vecs[16] = mk(0, 0, 0,          0, 0, 0,            1, 1, 9, 32'hAA,       1, 9, 1, 0);
        vecs[17] = mk(0, 0, 0,          0, 0, 0,            1, 0, 0, 0,            0, 0, 1, 0);
        vecs[18] = mk(1, 4, 32'h44,     0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0);
        vecs[19] = mk(1, 4, 32'h44,     0, 0, 0,            1, 1, 4, 32'h44,       0, 0, 1, 0);

        // Reset state
        #1 resetb_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_out("reset", 0, 0, 0, 0, 0, 1, 0);
        resetb_i = 1'b1;

        // Table: basic arbitration, x0 handling, clock-enable freeze
        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].exs_wr, vecs[i].exs_addr, vecs[i].exs_data,
                   vecs[i].lsq_wr, vecs[i].lsq_addr, vecs[i].lsq_data, vecs[i].en);
            #1;
            check_out($sformatf("row%0d", i), vecs[i].rf_wr, vecs[i].rf_addr, vecs[i].rf_data,
                      vecs[i].done, vecs[i].done_addr, vecs[i].rdy, vecs[i].hold);
            next_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 1);
        next_cycle();

        // Starvation: one entry queued behind 8 blocked EX cycles
        set_in(1, 2, 32'h22, 1, 6, 32'h66, 1);
        #1; check_out("t3 push", 1, 2, 32'h22, 0, 0, 1, 0);
        next_cycle();
        set_in(1, 2, 32'h22, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            #1; check_out($sformatf("t3 blk%0d", k), 1, 2, 32'h22, 0, 0, 1, 0);
            next_cycle();
        end
        #1; check_out("t3 hold", 1, 2, 32'h22, 0, 0, 1, 1);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 1);
        #1; check_out("t3 drain", 1, 6, 32'h66, 1, 6, 1, 1);
        next_cycle();
        #1; check_out("t3 release", 0, 0, 0, 0, 0, 1, 0);
        next_cycle();

        // FIFO full: 5 returns behind continuous EX writes
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1, 32'h11, 1, 5'(10 + k), 32'h100 + k, 1);
            #1; check_out($sformatf("t4 fill%0d", k), 1, 1, 32'h11, 0, 0, (k < 4), 0);
            next_cycle();
        end
        // EX stops; fifth return still held by the LSQ
        set_in(0, 0, 0, 1, 14, 32'h104, 1);
        #1; check_out("t4 drain0", 1, 10, 32'h100, 1, 10, 0, 0);
        next_cycle();
        #1; check_out("t4 drain1", 1, 11, 32'h101, 1, 11, 1, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 1);
        for (int k = 2; k < 5; k++) begin
            #1; check_out($sformatf("t4 drain%0d", k), 1, 5'(10 + k), 32'h100 + k, 1, 5'(10 + k), 1, 0);
            next_cycle();
        end
        #1; check_out("t4 empty", 0, 0, 0, 0, 0, 1, 0);
        next_cycle();

        // Reset mid-operation with 3 entries queued and hold raised
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 32'h11, 1, 5'(20 + k), 32'h200 + k, 1);
            next_cycle();
        end
        set_in(1, 1, 32'h11, 0, 0, 0, 1);
        repeat (10) next_cycle();
        #1; check_out("t6 pre", 1, 1, 32'h11, 0, 0, 1, 1);
        resetb_i = 1'b0;
        #1; check_out("t6 in reset", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        set_in(0, 0, 0, 0, 0, 0, 1);
        resetb_i = 1'b1;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            #1; check_out($sformatf("t6 post%0d", k), 0, 0, 0, 0, 0, 1, 0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
